la_trigger_config: RTL
======================

# la_trigger_config

UART command decoder sitting directly upstream of the logic analyzer core: consumes bytes from the UART receiver and drives the analyzer's four trigger-mask inputs and its capture reset. It replaces hard-wired trigger constants with host-loadable registers, arms a new capture on command and returns one acknowledge byte per command for the UART transmitter.

## Interface
- WIDTH, 128: trigger mask width in bits; must be a multiple of 8, ≥ 8.
- TIMEOUT, 20000: maximum idle cycles between bytes inside a load (1 ms at 20 MHz); ≥ 2.

- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- rx_data  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  one-cycle strobe per received byte (UART rxrdy).
- trigger_low  out  WIDTH  level-low mask to analyzer.
- trigger_high  out  WIDTH  level-high mask to analyzer.
- trigger_rising  out  WIDTH  rising-edge mask to analyzer.
- trigger_falling  out  WIDTH  falling-edge mask to analyzer.
- arm  out  1  one-cycle pulse driving the analyzer reset.
- busy  out  1  high while a load is in progress.
- ack_valid  out  1  acknowledge byte pending.
- ack_data  out  8  acknowledge byte.
- ack_ready  in  1  transmitter accepts ack_data when ack_valid && ack_ready.
- error  out  1  one-cycle pulse on a protocol error.

## Operation
- Opcodes: 0x01 load low, 0x02 load high, 0x03 load rising, 0x04 load falling, 0x10 arm, 0x11 clear all masks. Any other value is invalid.
- States: IDLE, LOAD.
- IDLE, rx_valid with a load opcode: latch target, byte count = 0, go to LOAD. With 0x10: pulse arm, ack 0x10. With 0x11: zero all four masks, ack 0x11. With an invalid opcode: pulse error, ack 0xEE, stay in IDLE.
- LOAD: each rx_valid shifts rx_data into the WIDTH-bit shift register, MSB first: the first byte lands at [WIDTH-1:WIDTH-8] after WIDTH/8 bytes. On byte WIDTH/8, copy the shift register to the target mask atomically, ack with the opcode, return to IDLE. Masks never show partial data.
- Timeout: the idle counter clears on entering LOAD and on every rx_valid, and increments otherwise. At TIMEOUT-1: discard the shift register, pulse error, ack 0xEE, go to IDLE. Target mask unchanged.
- Ack register is single-entry. A new ack while one is pending overwrites ack_data and keeps ack_valid high. Commands never stall.
- In LOAD, opcode values are treated as data (no resync).
- busy = (state == LOAD).

## Timing
- Reset values: all masks 0, arm 0, busy 0, ack_valid 0, ack_data 0x00, error 0, state IDLE, counters 0.
- reset_n low mid-load: the load is abandoned, no ack, and all outputs return to reset values on the next edge.
- Latency: the final load byte's rx_valid at edge N makes the mask, ack_valid and busy=0 visible after edge N. Arm/clear/error behave the same way, one cycle after the opcode strobe. arm is exactly one cycle wide.
- ack_valid clears on the edge where ack_valid && ack_ready. If a new ack is generated on that same edge, ack_valid stays high with the new data.
- rx_valid coinciding with timeout expiry: the byte wins, the counter clears and no error occurs.
- Back-to-back rx_valid on consecutive cycles is supported, with no bubbles needed.
- Width rules: byte counter is $clog2(WIDTH/8) bits, or 1 bit if WIDTH = 8. Idle counter is $clog2(TIMEOUT) bits and saturates.

## Structure
- Shared package la_pkg: opcode constants (OP_LOAD_LOW … OP_CLEAR), ACK_ERR = 8'hEE, and the state enum {IDLE, LOAD}. The analyzer-side testbench glue reuses these.
- One sub-module: la_idle_timer (clear / tick / expire; parameter TIMEOUT). Everything else stays in the top module.

## Test plan
- Reset, then send 0x03 followed by 16 bytes 0x00…0x0F, back-to-back → trigger_rising = 128'h000102…0F one cycle after the last byte; ack 0x03; other masks 0; busy high for the 16 bytes only.
- Send 0x01 and 5 bytes, then idle TIMEOUT cycles → error pulses once, ack 0xEE, trigger_low unchanged, busy drops. A following 0x10 → arm pulse of 1 cycle, ack 0x10.
- Send invalid opcode 0x7F while ack_ready = 0, then 0x10 → ack_data 0xEE then 0x10. After raising ack_ready: exactly one handshake, with value 0x10.
- Load all four masks with 0xFF, then send 0x11 → all four masks 0 the next cycle, ack 0x11.
- Pull reset_n low after the 8th byte of a load, then reload with 16 bytes of 0xA5 → no ack from the aborted load; mask = all-A5; no stale bytes.
- With WIDTH = 8 and TIMEOUT = 4: 0x02, 0x81 → trigger_high = 8'h81. A byte arriving on the exact expiry cycle is accepted, with no error.

Source files
------------

// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - opcodes, acknowledge codes and FSM states shared by the trigger configurator
package la_pkg;

   localparam logic [7:0] OP_LOAD_LOW     = 8'h01;
   localparam logic [7:0] OP_LOAD_HIGH    = 8'h02;
   localparam logic [7:0] OP_LOAD_RISING  = 8'h03;
   localparam logic [7:0] OP_LOAD_FALLING = 8'h04;
   localparam logic [7:0] OP_ARM          = 8'h10;
   localparam logic [7:0] OP_CLEAR        = 8'h11;
   localparam logic [7:0] ACK_ERR         = 8'hEE;

   typedef enum logic {
      IDLE,
      LOAD
   } state_t;

   function automatic logic is_load_op(input logic [7:0] op);
      return (op == OP_LOAD_LOW) || (op == OP_LOAD_HIGH) ||
             (op == OP_LOAD_RISING) || (op == OP_LOAD_FALLING);
   endfunction

endpackage

// File: rtl/la_idle_timer.sv
// rtl/la_idle_timer.sv - saturating inter-byte idle counter; expire flags the last idle cycle
module la_idle_timer #(
   parameter int TIMEOUT = 20000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic tick,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign expire = tick && (count == LIMIT);

endmodule

// File: rtl/la_trigger_config.sv
// rtl/la_trigger_config.sv - UART command decoder loading trigger masks, arming capture
// and returning one acknowledge byte per command.
module la_trigger_config
   import la_pkg::*;
#(
   parameter int WIDTH   = 128,
   parameter int TIMEOUT = 20000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic [WIDTH-1:0] trigger_low,
   output logic [WIDTH-1:0] trigger_high,
   output logic [WIDTH-1:0] trigger_rising,
   output logic [WIDTH-1:0] trigger_falling,
   output logic             arm,
   output logic             busy,
   output logic             ack_valid,
   output logic [7:0]       ack_data,
   input  logic             ack_ready,
   output logic             error
);

   localparam int BCW = (WIDTH == 8) ? 1 : $clog2(WIDTH / 8);
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(WIDTH / 8 - 1);

   state_t           state;
   logic [7:0]       target;
   logic [BCW-1:0]   byte_cnt;
   logic [WIDTH-1:0] shift;
   logic [WIDTH-1:0] shift_next;
   logic             expire;

   // Shifting by a full byte also covers WIDTH == 8, where the old contents fall off entirely.
   assign shift_next = (shift << 8) | WIDTH'(rx_data);
   assign busy       = (state == LOAD);

   la_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   ((state == IDLE) || rx_valid),
      .tick    (state == LOAD),
      .expire  (expire)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= IDLE;
         target          <= '0;
         byte_cnt        <= '0;
         shift           <= '0;
         trigger_low     <= '0;
         trigger_high    <= '0;
         trigger_rising  <= '0;
         trigger_falling <= '0;
         arm             <= 1'b0;
         error           <= 1'b0;
         ack_valid       <= 1'b0;
         ack_data        <= '0;
      end else begin
         arm   <= 1'b0;
         error <= 1'b0;
         // A fresh ack below overrides this retirement, keeping ack_valid high.
         if (ack_valid && ack_ready) begin
            ack_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (rx_valid) begin
                  if (is_load_op(rx_data)) begin
                     target   <= rx_data;
                     byte_cnt <= '0;
                     shift    <= '0;
                     state    <= LOAD;
                  end else if (rx_data == OP_ARM) begin
                     arm       <= 1'b1;
                     ack_valid <= 1'b1;
                     ack_data  <= OP_ARM;
                  end else if (rx_data == OP_CLEAR) begin
                     trigger_low     <= '0;
                     trigger_high    <= '0;
                     trigger_rising  <= '0;
                     trigger_falling <= '0;
                     ack_valid       <= 1'b1;
                     ack_data        <= OP_CLEAR;
                  end else begin
                     error     <= 1'b1;
                     ack_valid <= 1'b1;
                     ack_data  <= ACK_ERR;
                  end
               end
            end

            LOAD: begin
               // A byte on the expiry cycle wins over the timeout.
               if (rx_valid) begin
                  shift <= shift_next;
                  if (byte_cnt == LAST_BYTE) begin
                     case (target)
                        OP_LOAD_LOW:    trigger_low    <= shift_next;
                        OP_LOAD_HIGH:   trigger_high   <= shift_next;
                        OP_LOAD_RISING: trigger_rising <= shift_next;
                        default:        trigger_falling <= shift_next;
                     endcase
                     ack_valid <= 1'b1;
                     ack_data  <= target;
                     state     <= IDLE;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end else if (expire) begin
                  shift     <= '0;
                  error     <= 1'b1;
                  ack_valid <= 1'b1;
                  ack_data  <= ACK_ERR;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
